// File: rtl/lbl_scrub_fifo_pkg.sv
// Shared security-label types and helpers for the labelled scrub FIFO.
// Used by lbl_scrub_fifo and lbl_slot_array; LBL_SCRUB_CNT_EN is handled in those files.
package lbl_pkg;

    typedef enum logic {
        LVL_L = 1'b0,
        LVL_H = 1'b1
    } lvl_t;

    typedef enum logic {
        ST_RUN,
        ST_SCRUB
    } state_t;

    // True when a value labelled a may flow to a consumer cleared at b.
    function automatic logic lvl_leq(input lvl_t a, input lvl_t b);
        return (a == LVL_L) || (b == LVL_H);
    endfunction

endpackage

// File: rtl/lbl_scrub_fifo_slot_array.sv
// DEPTH x (W data + 1-bit tag) storage with write, scrub-clear and level-gated read.
// With LBL_SCRUB_CNT_EN defined, also keeps the saturating count of cleared slots.
module lbl_slot_array
    import lbl_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic          wr_lvl,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] rd_idx,
    input  logic          cur_lvl,
    output logic [W-1:0]  rd_data,
    output logic          rd_lvl
`ifdef LBL_SCRUB_CNT_EN
    ,
    output logic [7:0]    scrub_cnt
`endif
);

    logic [W-1:0]     data [DEPTH];
    logic [DEPTH-1:0] tag;
    logic             clr_hit;

    assign clr_hit = clr_en && tag[clr_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
            tag <= '0;
        end else begin
            if (clr_hit) begin
                data[clr_idx] <= '0;
                tag[clr_idx]  <= 1'b0;
            end
            if (wr_en) begin
                data[wr_idx] <= wr_data;
                tag[wr_idx]  <= wr_lvl;
            end
        end
    end

    always_comb begin
        rd_lvl  = tag[rd_idx];
        rd_data = lvl_leq(lvl_t'(tag[rd_idx]), lvl_t'(cur_lvl)) ? data[rd_idx] : '0;
    end

`ifdef LBL_SCRUB_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            scrub_cnt <= '0;
        end else if (clr_hit && (scrub_cnt != 8'hFF)) begin
            scrub_cnt <= scrub_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/lbl_scrub_fifo.sv
// Security-tagged output FIFO that scrubs H-tagged slots on every clearance drop.
// Optional macro LBL_SCRUB_CNT_EN adds the scrub_cnt output (count of cleared slots).
module lbl_scrub_fifo
    import lbl_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_lvl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_lvl,
    input  logic         cur_lvl,
    output logic         scrub_busy
`ifdef LBL_SCRUB_CNT_EN
    ,
    output logic [7:0]   scrub_cnt
`endif
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          cur_lvl_q;
    logic [AW-1:0] scrub_idx;

    logic          running, full, empty, push, pop, fall, downgrade;
    logic [AW-1:0] eff_idx;
    logic [W-1:0]  wr_data, rd_data;
    logic          wr_lvl, rd_lvl;

    always_comb begin
        running    = (state == ST_RUN);
        full       = (count == FULL_CNT);
        empty      = (count == '0);
        in_ready   = running && !full;
        out_valid  = running && !empty;
        scrub_busy = !running;
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        fall       = cur_lvl_q && !cur_lvl;
        downgrade  = !lvl_leq(lvl_t'(in_lvl), lvl_t'(cur_lvl));
        wr_data    = downgrade ? '0 : in_data;
        wr_lvl     = downgrade ? 1'b0 : in_lvl;
        // A fall inside a pass makes this cycle the first slot of a fresh pass.
        eff_idx    = fall ? '0 : scrub_idx;
        out_data   = empty ? '0 : rd_data;
        out_lvl    = empty ? 1'b0 : rd_lvl;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cur_lvl_q <= 1'b0;
            scrub_idx <= '0;
        end else begin
            cur_lvl_q <= cur_lvl;
            case (state)
                ST_RUN: begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop)  rd_ptr <= rd_ptr + 1'b1;
                    if (push && !pop)      count <= count + 1'b1;
                    else if (pop && !push) count <= count - 1'b1;
                    if (fall) begin
                        state     <= ST_SCRUB;
                        scrub_idx <= '0;
                    end
                end
                ST_SCRUB: begin
                    scrub_idx <= eff_idx + 1'b1;
                    if (eff_idx == LAST_IDX) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    lbl_slot_array #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_slots (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push),
        .wr_idx    (wr_ptr),
        .wr_data   (wr_data),
        .wr_lvl    (wr_lvl),
        .clr_en    (scrub_busy),
        .clr_idx   (eff_idx),
        .rd_idx    (rd_ptr),
        .cur_lvl   (cur_lvl),
        .rd_data   (rd_data),
        .rd_lvl    (rd_lvl)
`ifdef LBL_SCRUB_CNT_EN
        ,
        .scrub_cnt (scrub_cnt)
`endif
    );

endmodule

// File: tb/tb_lbl_scrub_fifo.sv
// Self-checking bench for lbl_scrub_fifo: directed scenarios plus random traffic vs a reference model.
// Define LBL_SCRUB_CNT_EN on both bench and RTL to also check scrub_cnt.
module tb_lbl_scrub_fifo;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_lvl;
    logic [W-1:0] in_data;
    logic         out_valid, out_ready, out_lvl;
    logic [W-1:0] out_data;
    logic         cur_lvl;
    logic         scrub_busy;
`ifdef LBL_SCRUB_CNT_EN
    logic [7:0]   scrub_cnt;
`endif

    lbl_scrub_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_lvl     (in_lvl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lvl    (out_lvl),
        .cur_lvl    (cur_lvl),
        .scrub_busy (scrub_busy)
`ifdef LBL_SCRUB_CNT_EN
        ,
        .scrub_cnt  (scrub_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: physical slot contents, FIFO occupancy, and remaining scrub cycles.
    int m_data [DEPTH];
    int m_lvl  [DEPTH];
    int m_head, m_cnt, m_q, m_busy_left, m_scnt;
    int obs_busy;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = 0;
            m_lvl[i]  = 0;
        end
        m_head = 0; m_cnt = 0; m_q = 0; m_busy_left = 0; m_scnt = 0;
    endtask

    task automatic step(input logic rst, input logic cur, input logic iv,
                        input logic [W-1:0] d, input logic l, input logic ordy);
        int  e_ir, e_ov, e_lvl, e_data, wpos;
        bit  busy, fall, do_push, do_pop, hide;
        @(negedge clk);
        reset = rst; cur_lvl = cur; in_valid = iv; in_data = d; in_lvl = l; out_ready = ordy;
        #1;
        busy = (m_busy_left > 0);
        e_ir = (!busy && m_cnt < DEPTH) ? 1 : 0;
        e_ov = (!busy && m_cnt > 0) ? 1 : 0;
        check("scrub_busy", 32'(scrub_busy), 32'(busy));
        check("in_ready", 32'(in_ready), 32'(e_ir));
        check("out_valid", 32'(out_valid), 32'(e_ov));
        if (!busy) begin
            hide   = (m_lvl[m_head] == 1) && (cur == 1'b0);
            e_lvl  = (m_cnt > 0) ? m_lvl[m_head] : 0;
            e_data = (m_cnt > 0 && !hide) ? m_data[m_head] : 0;
            check("out_lvl", 32'(out_lvl), 32'(e_lvl));
            check("out_data", 32'(out_data), 32'(e_data));
`ifdef LBL_SCRUB_CNT_EN
            check("scrub_cnt", 32'(scrub_cnt), 32'(m_scnt));
`endif
        end
        obs_busy = scrub_busy ? 1 : 0;

        fall = (m_q == 1) && (cur == 1'b0);
        if (!rst) begin
            model_reset();
        end else begin
            if (busy) begin
                m_busy_left = fall ? DEPTH - 1 : m_busy_left - 1;
            end else begin
                do_push = iv && (e_ir == 1);
                do_pop  = (e_ov == 1) && ordy;
                wpos    = (m_head + m_cnt) % DEPTH;
                if (do_push) begin
                    if (l && !cur) begin
                        m_data[wpos] = 0;
                        m_lvl[wpos]  = 0;
                    end else begin
                        m_data[wpos] = int'(d);
                        m_lvl[wpos]  = int'(l);
                    end
                end
                if (do_pop) m_head = (m_head + 1) % DEPTH;
                m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
                if (fall) begin
                    // Scrub outcome applied at once; nothing reads the slots until the pass ends.
                    for (int i = 0; i < DEPTH; i++) begin
                        if (m_lvl[i] == 1) begin
                            m_data[i] = 0;
                            m_lvl[i]  = 0;
                            if (m_scnt < 255) m_scnt++;
                        end
                    end
                    m_busy_left = DEPTH;
                end
            end
            m_q = int'(cur);
        end
    endtask

    task automatic idle(input logic cur);
        step(1'b1, cur, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic cur, input logic [W-1:0] d, input logic l);
        step(1'b1, cur, 1'b1, d, l, 1'b0);
    endtask

    task automatic pop(input logic cur);
        step(1'b1, cur, 1'b0, '0, 1'b0, 1'b1);
    endtask

    int busy_sum;

    initial begin
        reset = 1'b0; cur_lvl = 1'b0; in_valid = 1'b0; in_data = '0; in_lvl = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // In-order L traffic.
        idle(1'b0);
        push(1'b0, 4'd3, 1'b0);
        push(1'b0, 4'd5, 1'b0);
        push(1'b0, 4'd9, 1'b0);
        repeat (3) pop(1'b0);
        idle(1'b0);

        // Fill with H at clearance H, then push+pop at full.
        idle(1'b1);
        push(1'b1, 4'hA, 1'b1);
        push(1'b1, 4'hB, 1'b1);
        push(1'b1, 4'hC, 1'b1);
        push(1'b1, 4'hD, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'hE, 1'b1, 1'b1);
        idle(1'b1);
        check("in_ready_after_full_pop", 32'(in_ready), 32'd1);
        repeat (4) pop(1'b1);

        // Mixed H/L fill, then a clearance drop.
        push(1'b1, 4'd7, 1'b1);
        push(1'b1, 4'd2, 1'b0);
        push(1'b1, 4'd7, 1'b1);
        push(1'b1, 4'd2, 1'b0);
        idle(1'b0);
        busy_sum = 0;
        repeat (6) begin
            idle(1'b0);
            busy_sum += obs_busy;
        end
        check("scrub_len", 32'(busy_sum), 32'd4);
`ifdef LBL_SCRUB_CNT_EN
        check("scrub_cnt_two", 32'(scrub_cnt), 32'd2);
`endif
        check("count_kept_full", 32'(in_ready), 32'd0);
        repeat (4) pop(1'b0);

        // Write-side downgrade.
        push(1'b0, 4'hF, 1'b1);
        idle(1'b0);
        check("downgrade_data", 32'(out_data), 32'd0);
        check("downgrade_lvl", 32'(out_lvl), 32'd0);
        pop(1'b0);

        // Restart of a scrub by a second fall.
        push(1'b1, 4'd6, 1'b1);
        idle(1'b1);
        idle(1'b0);
        busy_sum = 0;
        idle(1'b0); busy_sum += obs_busy;
        idle(1'b1); busy_sum += obs_busy;
        idle(1'b0); busy_sum += obs_busy;
        repeat (6) begin
            idle(1'b0);
            busy_sum += obs_busy;
        end
        check("scrub_restart_len", 32'(busy_sum), 32'd6);

        // Reset in the middle of a scrub.
        push(1'b1, 4'd1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0);
        check("reset_mid_scrub_busy", 32'(scrub_busy), 32'd0);
        check("reset_mid_scrub_valid", 32'(out_valid), 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic c;
            c = cur_lvl;
            if ($urandom_range(0, 11) == 0) c = ~c;
            step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0, c,
                 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lbl_scrub_fifo.md
Name: lbl_scrub_fifo

Overview:
- Security-tagged output buffer downstream of the labelled compute stage; accepts registered 4-bit results, each tagged with a 1-bit level (0=L, 1=H).
- Stages results to a consumer partition whose clearance, cur_lvl, can change at run time.
- On a clearance drop (H->L), a fixed-duration scrub pass zeroes every H-tagged slot before any further traffic, so no H data reaches an L consumer.
- Scrub timing is independent of buffer contents.

Parameters:
- W, 4, data width per entry
- DEPTH, 4, number of slots; power of 2, >= 2
- AW, $clog2(DEPTH), pointer/index width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  upstream entry valid
- in_ready  output  1  buffer can accept
- in_data  input  W  upstream data
- in_lvl  input  1  tag of in_data
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head
- out_data  output  W  head data, level-gated
- out_lvl  output  1  head tag
- cur_lvl  input  1  consumer clearance; must be L-labelled
- scrub_busy  output  1  scrub pass in progress

Behaviour:
- Reset (reset==0 at posedge):
  - state=RUN; wr_ptr=rd_ptr=0; count=0.
  - All data slots = 0; all tags = 0; cur_lvl_q = 0.
  - Scrub index = 0; scrub_cnt = 0.
  - Outputs: in_ready=1 after reset, out_valid=0, out_data=0, out_lvl=0, scrub_busy=0.
- States: RUN, SCRUB.
- RUN:
  - in_ready = !full; out_valid = !empty.
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - A push is not accepted when full, even if a pop occurs that cycle.
- Write-side downgrade: if in_lvl=1 and cur_lvl=0 at push, store data=0 with tag=0. Otherwise store in_data/in_lvl as given.
- Read gating (combinational): out_data = (tag[rd_ptr] > cur_lvl) ? 0 : data[rd_ptr]; out_lvl = tag[rd_ptr]. When empty, out_data=0 and out_lvl=0.
- Pointer arithmetic: pointers wrap modulo DEPTH. count is AW+1 bits; full is count==DEPTH, empty is count==0.
- Clearance tracking:
  - cur_lvl_q <= cur_lvl every cycle.
  - fall = cur_lvl_q & ~cur_lvl.
  - A fall in RUN still completes that cycle's handshakes, with gating and downgrade using the current cur_lvl. Next state is SCRUB with index 0.
- SCRUB:
  - in_ready=0, out_valid=0, scrub_busy=1.
  - Each cycle visits physical slot index 0..DEPTH-1, valid or not. If tag[idx]==1: data<=0, tag<=0.
  - After slot DEPTH-1, return to RUN. Duration is exactly DEPTH cycles regardless of contents.
  - count and pointers are unchanged by a scrub.
- cur_lvl rise during SCRUB: the scrub completes unchanged. A new fall during SCRUB restarts the index at 0.
- Reset asserted during SCRUB: immediate return to the reset state.
- Labels: data slots are Par(tag); tags, pointers, count, state, index are L; in_ready, out_valid, scrub_busy are L.

Optional Feature:
- LBL_SCRUB_CNT_EN defined:
  - Adds output scrub_cnt [7:0], labelled H.
  - Increments by 1 for each slot actually cleared (tag was 1); saturates at 255; reset to 0.
  - Must not influence any L signal.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package lbl_pkg holds:
  - lvl_t (1-bit): LVL_L=0, LVL_H=1.
  - state enum: ST_RUN, ST_SCRUB.
  - A lvl_leq(a,b) function.
- One sub-module, lbl_slot_array: DEPTH x (W data + tag) storage with write port, scrub-clear port, and gated read port. FIFO control and the scrub FSM stay in the top module.

Test Plan:
- Reset, then push 3,5,9 (all L) with cur_lvl=0, pop 3 -> out_data 3,5,9 in order; out_valid=0 after; in_ready=1 throughout.
- cur_lvl=1: push 4 entries, tag H, data A,B,C,D -> in_ready=0 when count=4. Simultaneous push+pop at full -> push refused, count=3 next cycle.
- cur_lvl=1: fill 4 slots alternating H/L (data 7,2,7,2); drop cur_lvl to 0 -> scrub_busy=1 for exactly 4 cycles, in_ready=out_valid=0. Afterwards pops yield 0,2,0,2, all tags 0, count still 4.
- cur_lvl=0, push in_lvl=1 data F -> pops data 0, out_lvl 0. With LBL_SCRUB_CNT_EN, the scrub in the previous scenario leaves scrub_cnt=2.
- Drop cur_lvl, raise it at scrub cycle 1, drop again at cycle 2 -> scrub restarts; scrub_busy lasts 2+4=6 cycles total.
- reset=0 during scrub cycle 2 -> next cycle state RUN, count=0, scrub_busy=0, out_valid=0, all slots zero.
